execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_pkg.sv | 40 ++++
 rtl/execute_stage_if.sv | 37 +++
 rtl/execute_stage_md_unit.sv | 116 +++++++++++
 rtl/execute_stage.sv | 101 ++++++++++
 tb/tb_execute_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, MD iteration count,
// ALU/MD opcode encodings and the MD sequencer state type.
package execute_stage_pkg;

  localparam int INST_SIZE = 32;
  localparam int MD_CYCLES = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // Bit 2 set selects the divide family.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
interface ex_if #(
  parameter int W = execute_stage_pkg::INST_SIZE
);
  logic [W-1:0] SRC_A;
  logic [W-1:0] SRC_B;
  logic [3:0]   ALU_OP;
  logic         MD_VALID;
  logic [2:0]   MD_OP;
  logic [4:0]   RD_E;
  logic         ME_WE_E;
  logic         MEM_WE_E;
  logic         MEM_REG_E;
  logic [W-1:0] WD_E;
  logic         FLUSH;

  logic [W-1:0] ALU_OUT;
  logic [4:0]   RD;
  logic         ME_WE;
  logic         MEM_WE;
  logic         MEM_REG;
  logic [W-1:0] WD_ME;
  logic [W-1:0] BP_EX;
  logic         STALL_E;

  modport master (
    output SRC_A, SRC_B, ALU_OP, MD_VALID, MD_OP, RD_E, ME_WE_E, MEM_WE_E,
           MEM_REG_E, WD_E, FLUSH,
    input  ALU_OUT, RD, ME_WE, MEM_WE, MEM_REG, WD_ME, BP_EX, STALL_E
  );

  modport slave (
    input  SRC_A, SRC_B, ALU_OP, MD_VALID, MD_OP, RD_E, ME_WE_E, MEM_WE_E,
           MEM_REG_E, WD_E, FLUSH,
    output ALU_OUT, RD, ME_WE, MEM_WE, MEM_REG, WD_ME, BP_EX, STALL_E
  );
endinterface

// File: rtl/execute_stage_md_unit.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per BUSY
// cycle on operand magnitudes, sign fix-up applied to the DONE-cycle result.
module md_unit #(
  parameter int W      = execute_stage_pkg::INST_SIZE,
  parameter int CYCLES = execute_stage_pkg::MD_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       start_i,
  input  execute_stage_pkg::md_op_e  op_i,
  input  logic [W-1:0]               a_i,
  input  logic [W-1:0]               b_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [W-1:0]               result_o
);
  import execute_stage_pkg::*;

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  md_state_e     state_q;
  md_op_e        op_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q, acc_d, lo_q, lo_d, mcand_q, a_q;
  logic          neg_q, rneg_q, dz_q;

  logic          is_div, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    r_sh, diff, sum;
  logic [2*W-1:0] prod;

  always_comb begin
    is_div = op_i[2];
    a_neg  = (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a_i[W-1];
    b_neg  = (op_i inside {MD_MULH, MD_DIV, MD_REM}) & b_i[W-1];
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
  end

  // acc holds the product high half / partial remainder; lo holds the
  // multiplier being consumed / dividend shifting out as quotient shifts in.
  always_comb begin
    r_sh = {acc_q, lo_q[W-1]};
    diff = r_sh - {1'b0, mcand_q};
    sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    if (op_q[2]) begin
      if (!diff[W]) begin
        acc_d = diff[W-1:0];
        lo_d  = {lo_q[W-2:0], 1'b1};
      end else begin
        acc_d = r_sh[W-1:0];
        lo_d  = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      acc_d = sum[W:1];
      lo_d  = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: if (start_i) begin
          op_q    <= op_i;
          a_q     <= a_i;
          acc_q   <= '0;
          mcand_q <= is_div ? b_mag : a_mag;
          lo_q    <= is_div ? a_mag : b_mag;
          neg_q   <= a_neg ^ b_neg;
          rneg_q  <= a_neg;
          dz_q    <= is_div && (b_i == '0);
          cnt_q   <= CW'(CYCLES - 1);
          state_q <= MD_BUSY;
        end
        MD_BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          if (cnt_q == '0) state_q <= MD_DONE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

  // Divide-by-zero bypasses the sign fix-up so the quotient stays all ones.
  always_comb begin
    prod = {acc_q, lo_q};
    if (neg_q) prod = -prod;
    case (op_q)
      MD_MUL:                        result_o = prod[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod[2*W-1:W];
      MD_DIV, MD_DIVU:               result_o = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
      default:                       result_o = dz_q ? a_q : (rneg_q ? -acc_q : acc_q);
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative MD unit and the EX/MEM register.
// Stalls upstream while an MD op is in flight and inserts bubbles meanwhile.
module execute_stage #(
  parameter int INST_SIZE = execute_stage_pkg::INST_SIZE,
  parameter int MD_CYCLES = execute_stage_pkg::MD_CYCLES
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  import execute_stage_pkg::*;

  logic [INST_SIZE-1:0] alu_res, md_res;
  logic                 md_busy, md_done, md_start, stall;

  logic [INST_SIZE-1:0] alu_out_q, alu_out_d, wd_q, wd_d;
  logic [4:0]           rd_q, rd_d;
  logic                 me_we_q, me_we_d, mem_we_q, mem_we_d, mem_reg_q, mem_reg_d;

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.ALU_OP))
      ALU_ADD:   alu_res = bus.SRC_A + bus.SRC_B;
      ALU_SUB:   alu_res = bus.SRC_A - bus.SRC_B;
      ALU_AND:   alu_res = bus.SRC_A & bus.SRC_B;
      ALU_OR:    alu_res = bus.SRC_A | bus.SRC_B;
      ALU_XOR:   alu_res = bus.SRC_A ^ bus.SRC_B;
      ALU_SLL:   alu_res = bus.SRC_A << bus.SRC_B[4:0];
      ALU_SRL:   alu_res = bus.SRC_A >> bus.SRC_B[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(bus.SRC_A) >>> bus.SRC_B[4:0]);
      ALU_SLT:   alu_res = {{(INST_SIZE-1){1'b0}}, ($signed(bus.SRC_A) < $signed(bus.SRC_B))};
      ALU_SLTU:  alu_res = {{(INST_SIZE-1){1'b0}}, (bus.SRC_A < bus.SRC_B)};
      ALU_PASSB: alu_res = bus.SRC_B;
      default:   alu_res = '0;
    endcase
  end

  // A new MD op is only accepted from IDLE; in DONE the same instruction is
  // still presented and gets retired instead of restarted.
  assign md_start = bus.MD_VALID && !md_busy && !md_done;
  assign stall    = !bus.FLUSH && (md_busy || md_start);
  assign bus.STALL_E = stall;

  md_unit #(.W(INST_SIZE), .CYCLES(MD_CYCLES)) u_md (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (bus.FLUSH),
    .start_i  (md_start),
    .op_i     (md_op_e'(bus.MD_OP)),
    .a_i      (bus.SRC_A),
    .b_i      (bus.SRC_B),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // Bubbles are all-zero so the EX/MEM contents stay deterministic.
  always_comb begin
    alu_out_d = '0;
    rd_d      = '0;
    me_we_d   = 1'b0;
    mem_we_d  = 1'b0;
    mem_reg_d = 1'b0;
    wd_d      = '0;
    if (!bus.FLUSH && !stall) begin
      alu_out_d = bus.MD_VALID ? md_res : alu_res;
      rd_d      = bus.RD_E;
      me_we_d   = bus.ME_WE_E;
      mem_we_d  = bus.MEM_WE_E;
      mem_reg_d = bus.MEM_REG_E;
      wd_d      = bus.WD_E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      rd_q      <= '0;
      me_we_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_reg_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      alu_out_q <= alu_out_d;
      rd_q      <= rd_d;
      me_we_q   <= me_we_d;
      mem_we_q  <= mem_we_d;
      mem_reg_q <= mem_reg_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.ALU_OUT = alu_out_q;
  assign bus.BP_EX   = alu_out_q;
  assign bus.RD      = rd_q;
  assign bus.ME_WE   = me_we_q;
  assign bus.MEM_WE  = mem_we_q;
  assign bus.MEM_REG = mem_reg_q;
  assign bus.WD_ME   = wd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: randomized ALU/MD traffic against an
// arithmetic reference model, plus directed flush, reset and corner cases.
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam int W   = 32;
  localparam int MDC = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_if #(.W(W)) bus ();
  execute_stage #(.INST_SIZE(W), .MD_CYCLES(MDC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        me, mw, mr;
    logic [31:0] wd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int unsigned sh = b % 32;
    case (alu_op_e'(op))
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return 32'($signed(a) >>> sh);
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    int     qa = $signed(a);
    int     qb = $signed(b);
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (md_op_e'(op))
      MD_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(qa / qb);
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(qa % qb);
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle();
    bus.SRC_A = '0; bus.SRC_B = '0; bus.ALU_OP = '0; bus.MD_VALID = 1'b0;
    bus.MD_OP = '0; bus.RD_E = '0; bus.ME_WE_E = 1'b0; bus.MEM_WE_E = 1'b0;
    bus.MEM_REG_E = 1'b0; bus.WD_E = '0; bus.FLUSH = 1'b0;
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // following the capturing rising edge, with inputs idled.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] aop, input logic mdv, input logic [2:0] mop,
                       input logic [4:0] rd, input logic me, input logic mw,
                       input logic mr, input logic [31:0] wd);
    exp_t e;
    int n = 0;
    bus.SRC_A = a; bus.SRC_B = b; bus.ALU_OP = aop; bus.MD_VALID = mdv;
    bus.MD_OP = mop; bus.RD_E = rd; bus.ME_WE_E = me; bus.MEM_WE_E = mw;
    bus.MEM_REG_E = mr; bus.WD_E = wd; bus.FLUSH = 1'b0;
    forever begin
      #1;
      if (n > 0) chk({nm, "_bubble"}, {62'd0, bus.ME_WE, bus.MEM_WE}, 64'd0);
      if (!bus.STALL_E || n > 100) break;
      n++;
      @(negedge clk);
    end
    chk({nm, "_stall_cycles"}, 64'(n), mdv ? 64'(MDC + 1) : 64'd0);
    if (n <= 100) begin
      e.alu = mdv ? md_ref(a, b, mop) : alu_ref(a, b, aop);
      e.rd = rd; e.me = me; e.mw = mw; e.mr = mr; e.wd = wd;
      e.cyc = cyc + 1; e.name = nm;
      sbq.push_back(e);
    end
    @(negedge clk);
    idle();
  endtask

  // Monitor: every EX/MEM entry with a write enable is a retired instruction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && (bus.ME_WE || bus.MEM_WE)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", {bus.ALU_OUT, 27'd0, bus.RD}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_alu_bp"}, {bus.ALU_OUT, bus.BP_EX}, {e.alu, e.alu});
        chk({e.name, "_ctl_wd"}, {24'd0, bus.RD, bus.ME_WE, bus.MEM_WE, bus.MEM_REG, bus.WD_ME},
                                 {24'd0, e.rd, e.me, e.mw, e.mr, e.wd});
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    logic mdv, me;
    // Reset with a live instruction on the inputs: reset must win.
    rst = 1'b1;
    idle();
    bus.SRC_A = 32'd5; bus.SRC_B = 32'd3; bus.RD_E = 5'd9; bus.ME_WE_E = 1'b1;
    bus.MEM_WE_E = 1'b1; bus.MEM_REG_E = 1'b1; bus.WD_E = 32'hABCD; bus.FLUSH = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_alu_bp", {bus.ALU_OUT, bus.BP_EX}, 64'd0);
    chk("rst_ctl_wd", {24'd0, bus.RD, bus.ME_WE, bus.MEM_WE, bus.MEM_REG, bus.WD_ME}, 64'd0);
    bus.FLUSH = 1'b0;
    bus.MD_VALID = 1'b0;
    #1;
    chk("rst_stall", {63'd0, bus.STALL_E}, 64'd0);
    idle();
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    issue("add",    32'd5, 32'hFFFF_FFFD, ALU_ADD, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0);
    issue("div",    32'hFFFF_FFF9, 32'd2, 4'd0, 1'b1, MD_DIV, 5'd3, 1'b1, 1'b0, 1'b0, 32'd1);
    issue("rem",    32'hFFFF_FFF9, 32'd2, 4'd0, 1'b1, MD_REM, 5'd4, 1'b1, 1'b0, 1'b1, 32'd2);
    issue("divu0",  32'h1234, 32'd0, 4'd0, 1'b1, MD_DIVU, 5'd5, 1'b1, 1'b0, 1'b0, 32'd3);
    issue("remu0",  32'h1234, 32'd0, 4'd0, 1'b1, MD_REMU, 5'd6, 1'b1, 1'b0, 1'b0, 32'd4);
    issue("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b1, MD_DIV, 5'd8, 1'b1, 1'b0, 1'b0, 32'd5);
    issue("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 1'b1, MD_REM, 5'd9, 1'b0, 1'b1, 1'b0, 32'd6);
    issue("mulhu",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b1, MD_MULHU, 5'd10, 1'b1, 1'b0, 1'b0, 32'd7);
    issue("mul",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b1, MD_MUL, 5'd11, 1'b1, 1'b0, 1'b0, 32'd8);
    issue("sra",    32'h8000_0010, 32'h0000_0024, ALU_SRA, 1'b0, 3'd0, 5'd12, 1'b1, 1'b0, 1'b0, 32'd9);

    // Flush during BUSY: the DIV never retires and the unit is free at once.
    bus.SRC_A = 32'd100; bus.SRC_B = 32'd7; bus.MD_VALID = 1'b1; bus.MD_OP = MD_DIV;
    bus.RD_E = 5'd13; bus.ME_WE_E = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("busy_stall", {63'd0, bus.STALL_E}, 64'd1);
    bus.FLUSH = 1'b1;
    #1;
    chk("flush_stall", {63'd0, bus.STALL_E}, 64'd0);
    @(negedge clk);
    idle();
    #1;
    chk("flush_bubble", {62'd0, bus.ME_WE, bus.MEM_WE}, 64'd0);
    @(negedge clk);
    issue("add_after_flush", 32'd40, 32'd2, ALU_ADD, 1'b0, 3'd0, 5'd14, 1'b1, 1'b0, 1'b0, 32'd0);

    // Flush of an ALU op beats result capture.
    bus.SRC_A = 32'd1; bus.ALU_OP = ALU_ADD; bus.RD_E = 5'd15; bus.ME_WE_E = 1'b1;
    bus.MEM_WE_E = 1'b1; bus.FLUSH = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("flush_alu_bubble", {62'd0, bus.ME_WE, bus.MEM_WE}, 64'd0);
    @(negedge clk);

    // Reset mid-DIV: outputs cleared and nothing retires afterwards.
    issue("pre_rst_xor", 32'hF0F0_0000, 32'h0FF0_1234, ALU_XOR, 1'b0, 3'd0, 5'd16, 1'b1, 1'b1, 1'b1, 32'h55);
    bus.SRC_A = 32'hFFFF_FFF9; bus.SRC_B = 32'd2; bus.MD_VALID = 1'b1; bus.MD_OP = MD_DIV;
    bus.RD_E = 5'd17; bus.ME_WE_E = 1'b1;
    repeat (5) @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_alu_bp", {bus.ALU_OUT, bus.BP_EX}, 64'd0);
    chk("midrst_ctl_wd", {24'd0, bus.RD, bus.ME_WE, bus.MEM_WE, bus.MEM_REG, bus.WD_ME}, 64'd0);
    chk("midrst_stall", {63'd0, bus.STALL_E}, 64'd0);
    repeat (40) @(negedge clk);
    issue("add_after_rst", 32'd1, 32'd2, ALU_ADD, 1'b0, 3'd0, 5'd18, 1'b1, 1'b0, 1'b0, 32'd0);

    // Back-to-back MD ops followed by randomized traffic.
    issue("b2b_mulh",   32'h8000_0000, 32'h7FFF_FFFF, 4'd0, 1'b1, MD_MULH, 5'd19, 1'b1, 1'b0, 1'b0, 32'd0);
    issue("b2b_mulhsu", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd0, 1'b1, MD_MULHSU, 5'd20, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 120; i++) begin
      mdv = ($urandom_range(0, 3) == 0);
      me  = 1'($urandom_range(0, 1));
      issue(mdv ? "rnd_md" : "rnd_alu", rv(), rv(), 4'($urandom_range(0, 10)), mdv,
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), me,
            me ? 1'($urandom_range(0, 1)) : 1'b1, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
